// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared types, opcodes and opcode classifier for the decode stage
package rv_pkg;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int RAW   = $clog2(NREGS);

   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5
   } imm_fmt_e;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   typedef struct packed {
      imm_fmt_e fmt;
      logic     illegal;
   } opc_class_t;

   // Unknown opcodes fall back to R format so they carry no immediate.
   function automatic opc_class_t classify_opcode(input logic [6:0] opc);
      opc_class_t c;
      c.fmt     = FMT_R;
      c.illegal = 1'b0;
      case (opc)
         OPC_OP:                        c.fmt = FMT_R;
         OPC_OP_IMM, OPC_LOAD, OPC_JALR: c.fmt = FMT_I;
         OPC_STORE:                     c.fmt = FMT_S;
         OPC_BRANCH:                    c.fmt = FMT_B;
         OPC_LUI, OPC_AUIPC:            c.fmt = FMT_U;
         OPC_JAL:                       c.fmt = FMT_J;
         default:                       c.illegal = 1'b1;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/rv_regfile.sv
// rtl/rv_regfile.sv - 2R1W register file, x0 reads zero, write-through reads
module rv_regfile
   import rv_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic [RAW-1:0]  rs1_addr,
   input  logic [RAW-1:0]  rs2_addr,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   input  logic            wr_en,
   input  logic [RAW-1:0]  wr_addr,
   input  logic [XLEN-1:0] wr_data
);

   logic [XLEN-1:0] regs [NREGS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_en && wr_addr != '0) begin
         regs[wr_addr] <= wr_data;
      end
   end

   // Bypass the in-flight writeback so a same-cycle reader sees the new value.
   always_comb begin
      rs1_data = regs[rs1_addr];
      if (rs1_addr == '0)                   rs1_data = '0;
      else if (wr_en && wr_addr == rs1_addr) rs1_data = wr_data;
   end

   always_comb begin
      rs2_data = regs[rs2_addr];
      if (rs2_addr == '0)                   rs2_data = '0;
      else if (wr_en && wr_addr == rs2_addr) rs2_data = wr_data;
   end

endmodule

// File: rtl/rv_decode_stage.sv
// rtl/rv_decode_stage.sv - decode/operand stage: decoder, immediates, scoreboard, output register
module rv_decode_stage
   import rv_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            if_valid,
   output logic            if_ready,
   input  logic [31:0]     if_instr,
   input  logic [31:0]     if_pc,
   output logic            ex_valid,
   input  logic            ex_ready,
   output logic [31:0]     ex_instr,
   output logic [XLEN-1:0] ex_rs1_val,
   output logic [XLEN-1:0] ex_rs2_val,
   output logic [XLEN-1:0] ex_imm,
   output logic [31:0]     ex_pc,
   output logic [2:0]      ex_fmt,
   output logic            ex_illegal,
   input  logic            wb_en,
   input  logic [RAW-1:0]  wb_rd,
   input  logic [XLEN-1:0] wb_data
);

   opc_class_t      cls;
   imm_fmt_e        fmt;
   logic            illegal;
   logic [RAW-1:0]  rs1, rs2, rd;
   logic            uses_rs1, uses_rs2, writes_rd;
   logic [XLEN-1:0] rf_rs1, rf_rs2;
   logic [XLEN-1:0] imm;
   logic [NREGS-1:0] sb, busy, wb_clr, rd_set;
   logic            hazard, slot_free, issue;

   assign cls     = classify_opcode(if_instr[6:0]);
   assign fmt     = cls.fmt;
   assign illegal = cls.illegal;
   assign rs1     = if_instr[19:15];
   assign rs2     = if_instr[24:20];
   assign rd      = if_instr[11:7];

   assign uses_rs1  = !illegal && (fmt inside {FMT_R, FMT_I, FMT_S, FMT_B});
   assign uses_rs2  = !illegal && (fmt inside {FMT_R, FMT_S, FMT_B});
   assign writes_rd = !illegal && (fmt inside {FMT_R, FMT_I, FMT_U, FMT_J}) && (rd != '0);

   always_comb begin
      imm = '0;
      if (!illegal) begin
         case (fmt)
            FMT_I:   imm = {{20{if_instr[31]}}, if_instr[31:20]};
            FMT_S:   imm = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
            FMT_B:   imm = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                            if_instr[30:25], if_instr[11:8], 1'b0};
            FMT_U:   imm = {if_instr[31:12], 12'b0};
            FMT_J:   imm = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                            if_instr[20], if_instr[30:21], 1'b0};
            default: imm = '0;
         endcase
      end
   end

   rv_regfile u_rf (
      .clk      (clk),
      .rst      (rst),
      .rs1_addr (rs1),
      .rs2_addr (rs2),
      .rs1_data (rf_rs1),
      .rs2_data (rf_rs2),
      .wr_en    (wb_en),
      .wr_addr  (wb_rd),
      .wr_data  (wb_data)
   );

   // A writeback landing this cycle retires its pending bit before the hazard check.
   assign wb_clr = wb_en ? (NREGS'(1) << wb_rd) : '0;
   assign busy   = sb & ~wb_clr;
   assign hazard = (uses_rs1 && busy[rs1]) || (uses_rs2 && busy[rs2]) || (writes_rd && busy[rd]);

   assign slot_free = !ex_valid || ex_ready;
   assign if_ready  = slot_free && !hazard;
   assign issue     = if_valid && if_ready;

   assign rd_set = (issue && writes_rd) ? (NREGS'(1) << rd) : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sb <= '0;
      end else begin
         sb <= ((sb & ~wb_clr) | rd_set) & ~NREGS'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_valid   <= 1'b0;
         ex_instr   <= '0;
         ex_rs1_val <= '0;
         ex_rs2_val <= '0;
         ex_imm     <= '0;
         ex_pc      <= '0;
         ex_fmt     <= '0;
         ex_illegal <= 1'b0;
      end else if (issue) begin
         ex_valid   <= 1'b1;
         ex_instr   <= if_instr;
         ex_rs1_val <= uses_rs1 ? rf_rs1 : '0;
         ex_rs2_val <= uses_rs2 ? rf_rs2 : '0;
         ex_imm     <= imm;
         ex_pc      <= if_pc;
         ex_fmt     <= fmt;
         ex_illegal <= illegal;
      end else if (ex_ready) begin
         ex_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rv_decode_stage.sv
// tb/tb_rv_decode_stage.sv - directed self-checking bench for rv_decode_stage
module tb_rv_decode_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_valid, if_ready;
   logic [31:0] if_instr, if_pc;
   logic        ex_valid, ex_ready;
   logic [31:0] ex_instr, ex_rs1_val, ex_rs2_val, ex_imm, ex_pc;
   logic [2:0]  ex_fmt;
   logic        ex_illegal;
   logic        wb_en;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   rv_decode_stage dut (
      .clk        (clk),
      .rst        (rst),
      .if_valid   (if_valid),
      .if_ready   (if_ready),
      .if_instr   (if_instr),
      .if_pc      (if_pc),
      .ex_valid   (ex_valid),
      .ex_ready   (ex_ready),
      .ex_instr   (ex_instr),
      .ex_rs1_val (ex_rs1_val),
      .ex_rs2_val (ex_rs2_val),
      .ex_imm     (ex_imm),
      .ex_pc      (ex_pc),
      .ex_fmt     (ex_fmt),
      .ex_illegal (ex_illegal),
      .wb_en      (wb_en),
      .wb_rd      (wb_rd),
      .wb_data    (wb_data)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc = '0;
      ex_ready = 1'b1; wb_en = 1'b0; wb_rd = '0; wb_data = '0;
      step(); step();
      chk("rst_ex_valid", 32'(ex_valid), 32'd0);
      chk("rst_ex_instr", ex_instr, 32'd0);
      chk("rst_ex_imm", ex_imm, 32'd0);
      chk("rst_sb", dut.sb, 32'd0);
      rst = 1'b0;
      step();

      // 1: wb x5=0x10 then addi x6,x5,-1
      wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'h10;
      step();
      wb_en = 1'b0;
      if_valid = 1'b1; if_instr = 32'hFFF28313; if_pc = 32'h100;
      #1 chk("t1_if_ready", 32'(if_ready), 32'd1);
      step();
      if_valid = 1'b0;
      chk("t1_ex_valid", 32'(ex_valid), 32'd1);
      chk("t1_rs1", ex_rs1_val, 32'h10);
      chk("t1_imm", ex_imm, 32'hFFFFFFFF);
      chk("t1_fmt", 32'(ex_fmt), 32'd1);
      chk("t1_pc", ex_pc, 32'h100);
      chk("t1_illegal", 32'(ex_illegal), 32'd0);

      // 2: RAW on x7 cleared by same-cycle writeback
      if_valid = 1'b1; if_instr = 32'h00500393; if_pc = 32'h104;
      #1 chk("t2_first_ready", 32'(if_ready), 32'd1);
      step();
      if_instr = 32'h00138413; if_pc = 32'h108;
      #1 chk("t2_raw_stall", 32'(if_ready), 32'd0);
      step();
      chk("t2_bubble_valid", 32'(ex_valid), 32'd0);
      chk("t2_hold_instr", ex_instr, 32'h00500393);
      wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'h5;
      #1 chk("t2_wb_ready", 32'(if_ready), 32'd1);
      step();
      wb_en = 1'b0;
      chk("t2_valid", 32'(ex_valid), 32'd1);
      chk("t2_rs1", ex_rs1_val, 32'h5);
      chk("t2_imm", ex_imm, 32'h1);
      chk("t2_sb", dut.sb, 32'h0000_0140);

      // 3: backpressure holds output, then back-to-back transfers
      ex_ready = 1'b0;
      if_instr = 32'h00300493; if_pc = 32'h10C;
      for (int i = 0; i < 4; i++) begin
         #1 chk("t3_stall_ready", 32'(if_ready), 32'd0);
         step();
         chk("t3_hold_valid", 32'(ex_valid), 32'd1);
         chk("t3_hold_instr", ex_instr, 32'h00138413);
         chk("t3_hold_pc", ex_pc, 32'h108);
      end
      ex_ready = 1'b1;
      #1 chk("t3_release_ready", 32'(if_ready), 32'd1);
      step();
      chk("t3_b2b_instr0", ex_instr, 32'h00300493);
      if_instr = 32'h00700513; if_pc = 32'h110;
      #1 chk("t3_b2b_ready", 32'(if_ready), 32'd1);
      step();
      if_valid = 1'b0;
      chk("t3_b2b_valid", 32'(ex_valid), 32'd1);
      chk("t3_b2b_instr1", ex_instr, 32'h00700513);
      chk("t3_b2b_imm", ex_imm, 32'h7);

      // 4: store and branch immediates; x2 arrives by write-through
      wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'h1000;
      step();
      wb_rd = 5'd2; wb_data = 32'h55;
      if_valid = 1'b1; if_instr = 32'hFE20AE23; if_pc = 32'h114;
      step();
      wb_en = 1'b0;
      chk("t4_s_fmt", 32'(ex_fmt), 32'd2);
      chk("t4_s_imm", ex_imm, 32'hFFFFFFFC);
      chk("t4_s_rs1", ex_rs1_val, 32'h1000);
      chk("t4_s_rs2", ex_rs2_val, 32'h55);
      chk("t4_s_sb", dut.sb, 32'h0000_0740);
      if_instr = 32'hFE208CE3; if_pc = 32'h118;
      step();
      chk("t4_b_fmt", 32'(ex_fmt), 32'd3);
      chk("t4_b_imm", ex_imm, 32'hFFFFFFF8);
      chk("t4_b_rs2", ex_rs2_val, 32'h55);

      // 5: x0 stays zero; illegal opcode flows without side effects
      wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEAD;
      if_instr = 32'h00000633; if_pc = 32'h11C;
      step();
      wb_en = 1'b0;
      chk("t5_x0_rs1", ex_rs1_val, 32'd0);
      chk("t5_x0_rs2", ex_rs2_val, 32'd0);
      if_instr = 32'h000006B3; if_pc = 32'h120;
      step();
      chk("t5_x0_later", ex_rs1_val, 32'd0);
      if_instr = 32'hFFFFFFFF; if_pc = 32'h124;
      #1 chk("t5_ill_ready", 32'(if_ready), 32'd1);
      step();
      if_valid = 1'b0;
      chk("t5_ill_flag", 32'(ex_illegal), 32'd1);
      chk("t5_ill_imm", ex_imm, 32'd0);
      chk("t5_ill_fmt", 32'(ex_fmt), 32'd0);
      chk("t5_ill_rs1", ex_rs1_val, 32'd0);
      chk("t5_ill_sb", dut.sb, 32'h0000_3740);
      if_valid = 1'b1; if_instr = 32'h00100313;
      #1 chk("t5_waw_stall", 32'(if_ready), 32'd0);
      if_valid = 1'b0;
      step();

      // 6: asynchronous reset mid-transfer
      wb_en = 1'b1; wb_rd = 5'd6; wb_data = 32'h0;
      step();
      wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'h0;
      step();
      wb_en = 1'b0;
      if_valid = 1'b1; if_instr = 32'h00500393; if_pc = 32'h128;
      step();
      if_valid = 1'b0; ex_ready = 1'b0;
      chk("t6_pre_valid", 32'(ex_valid), 32'd1);
      chk("t6_pre_sb7", 32'(dut.sb[7]), 32'd1);
      #2 rst = 1'b1;
      #1 chk("t6_rst_valid", 32'(ex_valid), 32'd0);
      chk("t6_rst_sb", dut.sb, 32'd0);
      chk("t6_rst_instr", ex_instr, 32'd0);
      step();
      rst = 1'b0; ex_ready = 1'b1;
      if_valid = 1'b1; if_instr = 32'hFE20AE23; if_pc = 32'h200;
      #1 chk("t6_post_ready", 32'(if_ready), 32'd1);
      step();
      if_valid = 1'b0;
      chk("t6_post_valid", 32'(ex_valid), 32'd1);
      chk("t6_post_pc", ex_pc, 32'h200);
      chk("t6_rf_x1", ex_rs1_val, 32'd0);
      chk("t6_rf_x2", ex_rs2_val, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
